// File: rtl/hcpu_run_ctrl_if.sv
// Host/debug link, ROM write port and hCPU control bundle for the run controller.
// master = host/debug side driving commands, slave = the controller.
interface hcpu_run_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        load_last;
    logic        run_cmd;
    logic        step_cmd;
    logic        halt_cmd;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] cpu_pc;
    logic        cpu_reset;
    logic        cpu_clk_en;
    logic        rom_we;
    logic [15:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        halted;
    logic [15:0] load_count;
    logic        err;

    modport master (
        output load_valid, load_data, load_last, run_cmd, step_cmd, halt_cmd,
               bp_en, bp_addr, cpu_pc,
        input  load_ready, cpu_reset, cpu_clk_en, rom_we, rom_addr, rom_wdata,
               halted, load_count, err
    );

    modport slave (
        input  load_valid, load_data, load_last, run_cmd, step_cmd, halt_cmd,
               bp_en, bp_addr, cpu_pc,
        output load_ready, cpu_reset, cpu_clk_en, rom_we, rom_addr, rom_wdata,
               halted, load_count, err
    );
endinterface

// File: rtl/hcpu_run_ctrl.sv
// hCPU boot/run controller: byte-serial ROM load, timed reset release, run/step/halt/breakpoint gating.
// rom_we 1 cycle after the low byte; cpu_clk_en 1 cycle after run/step; load_ready drops after load or overflow.
module hcpu_run_ctrl #(
    parameter int ROM_DEPTH    = 32768,
    parameter int RESET_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    hcpu_run_ctrl_if.slave bus
);
    localparam int BCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        LOAD_HI,
        LOAD_LO,
        BOOT,
        RUN,
        STEP,
        HALT
    } state_t;

    state_t         state_q, state_d;
    logic           load_ready_q;
    logic           cpu_reset_q;
    logic           cpu_clk_en_q;
    logic           rom_we_q;
    logic           halted_q;
    logic           err_q;
    logic [15:0]    rom_addr_q;
    logic [15:0]    rom_wdata_q;
    logic [15:0]    load_count_q;
    logic [BCW-1:0] boot_cnt_q;

    logic accept;
    logic lo_accept;
    logic rom_full;
    logic ovf;
    logic boot_done;
    logic bp_hit;

    assign accept    = bus.load_valid & load_ready_q;
    assign lo_accept = (state_q == LOAD_LO) & accept;
    // The word being written now is the last slot of the ROM.
    assign rom_full  = (({1'b0, load_count_q} + 17'd1) == 17'(ROM_DEPTH));
    assign ovf       = lo_accept & ~bus.load_last & rom_full;
    assign boot_done = (boot_cnt_q == BCW'(RESET_CYCLES - 1));
    assign bp_hit    = (state_q == RUN) & bus.bp_en & (bus.cpu_pc == bus.bp_addr);

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_HI: if (accept) state_d = LOAD_LO;
            LOAD_LO: begin
                if (accept) begin
                    if (bus.load_last)  state_d = BOOT;
                    else if (rom_full)  state_d = HALT;
                    else                state_d = LOAD_HI;
                end
            end
            BOOT:    if (boot_done) state_d = HALT;
            // An overflowed load leaves the CPU parked in reset until controller reset.
            HALT: begin
                if (!err_q) begin
                    if (bus.step_cmd)     state_d = STEP;
                    else if (bus.run_cmd) state_d = RUN;
                end
            end
            RUN:     if (bp_hit || bus.halt_cmd) state_d = HALT;
            STEP:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD_HI;
            load_ready_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
            cpu_clk_en_q <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_wdata_q  <= '0;
            halted_q     <= 1'b0;
            load_count_q <= '0;
            err_q        <= 1'b0;
            boot_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            load_ready_q <= (state_d == LOAD_HI) || (state_d == LOAD_LO);
            cpu_clk_en_q <= (state_d == RUN) || (state_d == STEP);
            halted_q     <= (state_d == HALT);
            cpu_reset_q  <= (state_d inside {LOAD_HI, LOAD_LO, BOOT}) ||
                            ((state_d == HALT) && (err_q || ovf));
            err_q        <= err_q | ovf;
            rom_we_q     <= lo_accept;

            if ((state_q == LOAD_HI) && accept) begin
                rom_wdata_q[15:8] <= bus.load_data;
            end
            if (lo_accept) begin
                rom_wdata_q[7:0] <= bus.load_data;
                rom_addr_q       <= load_count_q;
                load_count_q     <= load_count_q + 16'd1;
            end

            if (state_q != BOOT) begin
                boot_cnt_q <= '0;
            end else if (!boot_done) begin
                boot_cnt_q <= boot_cnt_q + BCW'(1);
            end
        end
    end

    // Breakpoint gating is combinational so the instruction at bp_addr never gets a clock.
    assign bus.cpu_clk_en = cpu_clk_en_q & ~bp_hit;
    assign bus.load_ready = load_ready_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.rom_we     = rom_we_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_wdata  = rom_wdata_q;
    assign bus.halted     = halted_q;
    assign bus.load_count = load_count_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_hcpu_run_ctrl.sv
// Bench for hcpu_run_ctrl: table-driven load/step vectors, ROM write scoreboard, breakpoint, overflow, async reset.
module tb_hcpu_run_ctrl;
    logic clock;
    logic reset;

    hcpu_run_ctrl_if bus_a ();
    hcpu_run_ctrl_if bus_b ();

    hcpu_run_ctrl #(.ROM_DEPTH(32768), .RESET_CYCLES(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    hcpu_run_ctrl #(.ROM_DEPTH(2), .RESET_CYCLES(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        last;
        logic        run;
        logic        step;
        logic        halt;
        logic        e_ready;
        logic        e_rst;
        logic        e_halted;
        logic        e_en;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  qa[$];
    wr_t  qb[$];

    int checks   = 0;
    int errors   = 0;
    int en_cnt_a = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic v, input logic [7:0] d, input logic last,
                                 input logic run, input logic step, input logic halt,
                                 input logic e_ready, input logic e_rst, input logic e_halted,
                                 input logic e_en, input logic [15:0] e_cnt);
        vec_t r;
        r = {v, d, last, run, step, halt, e_ready, e_rst, e_halted, e_en, e_cnt};
        return r;
    endfunction

    // Called away from the clock edge: checks ROM writes, then advances one cycle and
    // models the CPU advancing its pc on every enabled cycle.
    task automatic tick();
        logic en;
        wr_t  w;
        en = bus_a.cpu_clk_en;
        if (bus_a.rom_we) begin
            wr_cnt_a++;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL rom_a_unexpected: got write %0h@%0h expected none", bus_a.rom_wdata, bus_a.rom_addr);
            end else begin
                w = qa.pop_front();
                checks--;
                check("rom_a_write", {bus_a.rom_addr, bus_a.rom_wdata}, w);
            end
        end
        if (bus_b.rom_we) begin
            wr_cnt_b++;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL rom_b_unexpected: got write %0h@%0h expected none", bus_b.rom_wdata, bus_b.rom_addr);
            end else begin
                w = qb.pop_front();
                checks--;
                check("rom_b_write", {bus_b.rom_addr, bus_b.rom_wdata}, w);
            end
        end
        @(posedge clock);
        #1;
        if (en) begin
            en_cnt_a++;
            bus_a.cpu_pc = bus_a.cpu_pc + 16'd1;
        end
    endtask

    initial begin
        logic        phase;
        logic [7:0]  hi;
        logic [15:0] word;
        int          n;
        int          en_base;
        int          acc_b;
        logic [7:0]  hi_b;

        reset = 1'b0;
        {bus_a.load_valid, bus_a.load_data, bus_a.load_last} = '0;
        {bus_a.run_cmd, bus_a.step_cmd, bus_a.halt_cmd, bus_a.bp_en} = '0;
        bus_a.bp_addr = '0;
        bus_a.cpu_pc  = '0;
        {bus_b.load_valid, bus_b.load_data, bus_b.load_last} = '0;
        {bus_b.run_cmd, bus_b.step_cmd, bus_b.halt_cmd, bus_b.bp_en} = '0;
        bus_b.bp_addr = '0;
        bus_b.cpu_pc  = '0;

        // last on a high byte must be ignored; a 5-cycle stall sits mid-word.
        vecs.push_back(mkv(1, 8'hE3, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mkv(1, 8'h08, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mkv(1, 8'hEA, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mkv(1, 8'h87, 1, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        for (int s = 0; s < 3; s++) begin
            vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0, 2));
            vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2));
            vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 2));
            vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        end
        vecs.push_back(mkv(0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 2));

        repeat (2) @(posedge clock);
        #2;
        check("reset_a", {bus_a.load_ready, bus_a.cpu_reset, bus_a.cpu_clk_en, bus_a.rom_we,
                          bus_a.rom_addr, bus_a.rom_wdata, bus_a.halted, bus_a.load_count, bus_a.err},
              {1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0});
        check("reset_b", {bus_b.load_ready, bus_b.cpu_reset, bus_b.halted, bus_b.err},
              {1'b1, 1'b1, 1'b0, 1'b0});
        reset = 1'b1;

        phase = 1'b0;
        hi    = '0;
        word  = '0;
        foreach (vecs[i]) begin
            bus_a.load_valid = vecs[i].v;
            bus_a.load_data  = vecs[i].d;
            bus_a.load_last  = vecs[i].last;
            bus_a.run_cmd    = vecs[i].run;
            bus_a.step_cmd   = vecs[i].step;
            bus_a.halt_cmd   = vecs[i].halt;
            #1;
            check($sformatf("vec%0d", i),
                  {bus_a.load_ready, bus_a.cpu_reset, bus_a.halted, bus_a.cpu_clk_en, bus_a.load_count},
                  {vecs[i].e_ready, vecs[i].e_rst, vecs[i].e_halted, vecs[i].e_en, vecs[i].e_cnt});
            if (vecs[i].v && vecs[i].e_ready) begin
                if (!phase) hi = vecs[i].d;
                else begin
                    qa.push_back({word, hi, vecs[i].d});
                    word++;
                end
                phase = ~phase;
            end
            tick();
        end
        {bus_a.load_valid, bus_a.run_cmd, bus_a.step_cmd, bus_a.halt_cmd} = '0;
        #1;
        check("step_enables", en_cnt_a, 4);
        check("load_writes", wr_cnt_a, 2);

        // Breakpoint: run from pc 0, must stop with pc parked on bp_addr.
        bus_a.cpu_pc  = 16'd0;
        bus_a.bp_en   = 1'b1;
        bus_a.bp_addr = 16'd5;
        en_base       = en_cnt_a;
        bus_a.run_cmd = 1'b1;
        tick();
        bus_a.run_cmd = 1'b0;
        n = 0;
        while (bus_a.cpu_pc != 16'd5 && n < 20) begin
            #1;
            tick();
            n++;
        end
        #1;
        check("bp_reached_pc", bus_a.cpu_pc, 16'd5);
        check("bp_clk_en_drop", bus_a.cpu_clk_en, 1'b0);
        check("bp_enable_count", en_cnt_a - en_base, 5);
        tick();
        #1;
        check("bp_halted", {bus_a.halted, bus_a.cpu_clk_en, bus_a.cpu_pc}, {1'b1, 1'b0, 16'd5});
        bus_a.step_cmd = 1'b1;
        tick();
        bus_a.step_cmd = 1'b0;
        #1;
        check("step_off_bp", {bus_a.halted, bus_a.cpu_clk_en}, {1'b0, 1'b1});
        tick();
        #1;
        check("after_step", {bus_a.halted, bus_a.cpu_clk_en, bus_a.cpu_pc}, {1'b1, 1'b0, 16'd6});
        bus_a.run_cmd = 1'b1;
        tick();
        bus_a.run_cmd = 1'b0;
        #1;
        check("resume_run", {bus_a.halted, bus_a.cpu_clk_en}, {1'b0, 1'b1});
        tick();
        #1;
        tick();
        bus_a.halt_cmd = 1'b1;
        #1;
        check("halt_cycle_still_en", {bus_a.cpu_clk_en, bus_a.cpu_pc}, {1'b1, 16'd8});
        tick();
        bus_a.halt_cmd = 1'b0;
        #1;
        check("halt_stop", {bus_a.halted, bus_a.cpu_clk_en, bus_a.cpu_pc}, {1'b1, 1'b0, 16'd9});

        // Overflow on a 2-word ROM: 6 bytes, no last; only 4 may be taken.
        acc_b = 0;
        hi_b  = '0;
        for (int i = 1; i <= 6; i++) begin
            bus_b.load_valid = 1'b1;
            bus_b.load_data  = 8'(i);
            bus_b.load_last  = 1'b0;
            #1;
            check($sformatf("ovf_ready%0d", i), bus_b.load_ready, (acc_b < 4));
            if (acc_b < 4) begin
                if (acc_b % 2 == 0) hi_b = 8'(i);
                else qb.push_back({16'(acc_b / 2), hi_b, 8'(i)});
                acc_b++;
            end
            tick();
        end
        bus_b.load_valid = 1'b0;
        #1;
        check("ovf_state", {bus_b.err, bus_b.load_ready, bus_b.halted, bus_b.cpu_reset,
                            bus_b.cpu_clk_en, bus_b.load_count},
              {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2});
        tick();
        #1;
        tick();
        #1;
        check("ovf_writes", wr_cnt_b, 2);
        check("ovf_sb_empty", qb.size(), 0);
        check("ovf_err_sticky", bus_b.err, 1'b1);

        // Async reset in RUN, then a fresh load.
        bus_a.bp_en   = 1'b0;
        bus_a.run_cmd = 1'b1;
        tick();
        bus_a.run_cmd = 1'b0;
        #1;
        check("pre_reset_run", bus_a.cpu_clk_en, 1'b1);
        reset = 1'b0;
        #1;
        check("async_reset_a", {bus_a.load_ready, bus_a.cpu_reset, bus_a.cpu_clk_en, bus_a.rom_we,
                                bus_a.rom_addr, bus_a.rom_wdata, bus_a.halted, bus_a.load_count, bus_a.err},
              {1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0});
        check("async_reset_b_err", bus_b.err, 1'b0);
        reset = 1'b1;
        tick();
        #1;
        check("post_reset", {bus_a.load_ready, bus_a.load_count, bus_a.halted}, {1'b1, 16'd0, 1'b0});
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 8'h12;
        bus_a.load_last  = 1'b0;
        tick();
        bus_a.load_data  = 8'h34;
        bus_a.load_last  = 1'b1;
        qa.push_back({16'd0, 16'h1234});
        #1;
        tick();
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'b0;
        #1;
        tick();
        #1;
        check("reload_count", bus_a.load_count, 16'd1);
        check("reload_writes", wr_cnt_a, 3);
        check("sb_a_empty", qa.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
